// File: rtl/tracker_pkg.sv
// Shared tracker types: recorder payload, log entry layout and log arbiter limits.
package tracker_pkg;

  localparam int unsigned TRACKER_STATS_W         = 64;
  localparam int unsigned TRACKER_LOG_ARB_MAX_REQ = 16;
  localparam int unsigned TRACKER_LOG_REQ_ID_W    = $clog2(TRACKER_LOG_ARB_MAX_REQ);

  typedef struct packed {
    logic [TRACKER_STATS_W-1:0] payload;
  } tracker_stats_struct;

  // Widest log entry; narrower arbiters pack the same order with a shorter req_id.
  typedef struct packed {
    logic [TRACKER_LOG_REQ_ID_W-1:0] req_id;
    tracker_stats_struct             stats;
  } tracker_log_entry_struct;

  localparam int unsigned TRACKER_LOG_ENTRY_W = $bits(tracker_log_entry_struct);

endpackage

// File: rtl/tracker_rr_arb.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module tracker_rr_arb
  import tracker_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [PTR_W:0] idx;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tracker_log_arb.sv
// Funnels NUM_REQ tracker recorders into one simple_log write port via one-entry slots.
// Optional macro TRACKER_LOG_ARB_DROP_CNT_EN builds the per-requester drop counters.
module tracker_log_arb
  import tracker_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_W     = 64,
  parameter  int unsigned DROP_CNT_W = 16,
  localparam int unsigned REQ_ID_W   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_val,
  input  logic [NUM_REQ*DATA_W-1:0]      req_data,
  input  logic                           freeze,
  input  logic                           drop_cnt_clr,
  output logic                           log_wr_req_val,
  output logic [REQ_ID_W+DATA_W-1:0]     log_wr_req_data,
  output logic [NUM_REQ-1:0]             slot_pending,
  output logic [NUM_REQ*DROP_CNT_W-1:0]  drop_cnt
);

  logic [NUM_REQ-1:0]  slot_full;
  logic [DATA_W-1:0]   slot_data [NUM_REQ];
  logic [REQ_ID_W-1:0] rr_ptr;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  drop;
  logic [REQ_ID_W-1:0] win_idx;
  logic                win_any;

  assign eligible = freeze ? '0 : slot_full;

  tracker_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = REQ_ID_W'(i);
    end
  end

  assign win_any         = |grant;
  assign log_wr_req_val  = win_any;
  assign log_wr_req_data = win_any ? {win_idx, slot_data[win_idx]} : '0;
  assign slot_pending    = slot_full;
  assign drop            = slot_full & ~grant & req_val;

  // A new pulse always leaves the slot FULL; it only replaces the record if the slot frees this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_full <= '0;
      rr_ptr    <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) slot_data[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_val[i]) begin
          slot_full[i] <= 1'b1;
          if (!slot_full[i] || grant[i]) slot_data[i] <= req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
      if (win_any) rr_ptr <= (win_idx == REQ_ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

`ifdef TRACKER_LOG_ARB_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) drop_cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (drop_cnt_clr)                       drop_cnt_q[i] <= '0;
        else if (drop[i] && drop_cnt_q[i] != '1) drop_cnt_q[i] <= drop_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] = drop_cnt_q[i];
  end
`else
  logic unused_drop;
  assign unused_drop = ^{drop, drop_cnt_clr};
  assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_tracker_log_arb.sv
// Directed bench for tracker_log_arb: latency, RR order, freeze, refill, saturation, async reset.
module tb_tracker_log_arb;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned DROP_CNT_W = 16;
  localparam int unsigned REQ_ID_W   = 2;

`ifdef TRACKER_LOG_ARB_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          rst = 1'b0;
  logic [NUM_REQ-1:0]            req_val = '0;
  logic [NUM_REQ*DATA_W-1:0]     req_data = '0;
  logic                          freeze = 1'b0;
  logic                          drop_cnt_clr = 1'b0;
  logic                          log_wr_req_val;
  logic [REQ_ID_W+DATA_W-1:0]    log_wr_req_data;
  logic [NUM_REQ-1:0]            slot_pending;
  logic [NUM_REQ*DROP_CNT_W-1:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tracker_log_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DROP_CNT_W(DROP_CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_val         (req_val),
    .req_data        (req_data),
    .freeze          (freeze),
    .drop_cnt_clr    (drop_cnt_clr),
    .log_wr_req_val  (log_wr_req_val),
    .log_wr_req_data (log_wr_req_data),
    .slot_pending    (slot_pending),
    .drop_cnt        (drop_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #2;
    rst = 1'b0;
    req_val = '0;
    req_data = '0;
    freeze = 1'b0;
    drop_cnt_clr = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic set_req(input int id, input logic [DATA_W-1:0] d);
    req_val[id] = 1'b1;
    req_data[id*DATA_W +: DATA_W] = d;
  endtask

  function automatic logic [REQ_ID_W+DATA_W-1:0] ent(input int id, input logic [DATA_W-1:0] d);
    logic [31:0] idv;
    idv = id;
    return {idv[REQ_ID_W-1:0], d};
  endfunction

  function automatic logic [DROP_CNT_W-1:0] dc(input int id);
    return drop_cnt[id*DROP_CNT_W +: DROP_CNT_W];
  endfunction

  initial begin
    // Reset state
    rst = 1'b0;
    #3;
    chk("rst_val", log_wr_req_val, 0);
    chk("rst_data", log_wr_req_data, 0);
    chk("rst_pending", slot_pending, 0);
    chk("rst_drop", drop_cnt, 0);
    #4;
    rst = 1'b1;
    tick();

    // 1: single requester, one-cycle latency
    set_req(2, 64'hAA);
    settle();
    chk("t1_no_early_write", log_wr_req_val, 0);
    tick();
    req_val = '0;
    settle();
    chk("t1_val", log_wr_req_val, 1);
    chk("t1_data", log_wr_req_data, ent(2, 64'hAA));
    chk("t1_pending", slot_pending, 4'b0100);
    tick();
    settle();
    chk("t1_val_off", log_wr_req_val, 0);
    chk("t1_data_zero", log_wr_req_data, 0);
    chk("t1_pending_clr", slot_pending, 0);

    // 2: all requesters at once drain 0..3, pointer wraps to 0
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 64'h100 + 64'(i));
    tick();
    req_val = '0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t2_val_%0d", i), log_wr_req_val, 1);
      chk($sformatf("t2_data_%0d", i), log_wr_req_data, ent(i, 64'h100 + 64'(i)));
      chk($sformatf("t2_pend_%0d", i), slot_pending, (4'b1111 << i) & 4'hF);
      tick();
    end
    settle();
    chk("t2_idle", log_wr_req_val, 0);
    chk("t2_no_drops", drop_cnt, 0);
    set_req(3, 64'h203);
    set_req(0, 64'h200);
    tick();
    req_val = '0;
    settle();
    chk("t2_ptr0_first", log_wr_req_data, ent(0, 64'h200));
    tick();
    settle();
    chk("t2_ptr0_second", log_wr_req_data, ent(3, 64'h203));
    tick();

    // 3: freeze holds the first record, drops the second, releases same cycle
    do_reset();
    freeze = 1'b1;
    tick(); tick();
    set_req(1, 64'h11);
    tick();
    req_val = '0;
    settle();
    chk("t3_frozen_val", log_wr_req_val, 0);
    chk("t3_frozen_pend", slot_pending, 4'b0010);
    tick(); tick(); tick(); tick();
    set_req(1, 64'h22);
    tick();
    req_val = '0;
    settle();
    chk("t3_frozen_val2", log_wr_req_val, 0);
    chk("t3_drop1", dc(1), CNT_EN ? 16'd1 : 16'd0);
    tick(); tick();
    freeze = 1'b0;
    settle();
    chk("t3_release_val", log_wr_req_val, 1);
    chk("t3_release_data", log_wr_req_data, ent(1, 64'h11));
    tick();
    settle();
    chk("t3_drained", slot_pending, 0);
    chk("t3_single_write", log_wr_req_val, 0);

    // 4: back-to-back pulses on requester 0 are granted and refilled without drops
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) set_req(0, 64'h40 + 64'(k));
      else req_val = '0;
      settle();
      if (k > 0) begin
        chk($sformatf("t4_val_%0d", k), log_wr_req_val, 1);
        chk($sformatf("t4_data_%0d", k), log_wr_req_data, ent(0, 64'h40 + 64'(k - 1)));
      end
      tick();
    end
    settle();
    chk("t4_end_idle", log_wr_req_val, 0);
    chk("t4_no_drops", drop_cnt, 0);

    // 5: saturation under freeze, clear beats a same-cycle drop
    do_reset();
    freeze = 1'b1;
    set_req(3, 64'h33);
    for (int k = 0; k < 70001; k++) tick();
    settle();
    chk("t5_saturated", dc(3), CNT_EN ? 16'hFFFF : 16'h0);
    chk("t5_frozen_val", log_wr_req_val, 0);
    drop_cnt_clr = 1'b1;
    tick();
    drop_cnt_clr = 1'b0;
    settle();
    chk("t5_clr_priority", dc(3), 0);
    tick();
    settle();
    chk("t5_count_resumes", dc(3), CNT_EN ? 16'd1 : 16'd0);
    req_val = '0;

    // 6: async reset mid-cycle with pending slots
    do_reset();
    freeze = 1'b1;
    set_req(0, 64'hA0);
    set_req(2, 64'hA2);
    tick();
    set_req(2, 64'hB2);
    tick();
    req_val = '0;
    freeze = 1'b0;
    settle();
    chk("t6_pre_val", log_wr_req_val, 1);
    chk("t6_pre_pend", slot_pending, 4'b0101);
    chk("t6_pre_drop", dc(2), CNT_EN ? 16'd1 : 16'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_val", log_wr_req_val, 0);
    chk("t6_rst_pend", slot_pending, 0);
    chk("t6_rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      settle();
      chk($sformatf("t6_no_stale_%0d", k), log_wr_req_val, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tracker_log_arb.md
Name: tracker_log_arb

Overview:
Shares one simple_log write port among NUM_REQ fire-and-forget tracker recorders (tracker_record_ctrl/datap instances on different NoC links). Each requester gets a one-entry holding slot. A round-robin arbiter drains one slot per cycle into the log, tagging each record with the requester ID. A freeze input lets the log reader stop writes while it dumps the log, and per-requester drop counters expose any lost records.

Parameters:
NUM_REQ, 4, number of recorders sharing the log (2..16)
DATA_W, 64, width of one tracker record (TRACKER_STATS_W)
REQ_ID_W, $clog2(NUM_REQ), width of the requester tag (derived; not overridden)
DROP_CNT_W, 16, width of each saturating drop counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
req_val  in  NUM_REQ  per-requester record valid; no ready, one-cycle pulse per record
req_data  in  NUM_REQ*DATA_W  records, flattened; requester i occupies bits [i*DATA_W +: DATA_W]
freeze  in  1  1 = inhibit all log writes
drop_cnt_clr  in  1  synchronous clear of all drop counters
log_wr_req_val  out  1  write strobe to simple_log
log_wr_req_data  out  REQ_ID_W+DATA_W  {req_id, record}, req_id in the MSBs
slot_pending  out  NUM_REQ  slot i holds an unwritten record
drop_cnt  out  NUM_REQ*DROP_CNT_W  per-requester dropped-record counts, flattened

Behaviour:
- Reset (rst=0, async): all slots empty; RR pointer = 0; drop counters = 0; log_wr_req_val=0; log_wr_req_data=0; slot_pending=0; drop_cnt=0.
- Slot state per requester: EMPTY/FULL.
  - EMPTY & req_val -> FULL; record is captured at the edge.
  - FULL & granted & req_val -> stays FULL with the new record; no drop.
  - FULL & granted & !req_val -> EMPTY.
  - FULL & !granted & req_val -> stays FULL with the old record; the new record is dropped and drop_cnt[i] increments.
- Arbitration (combinational):
  - Eligible set = FULL slots, masked to none when freeze=1.
  - Search starts at the RR pointer, ascending with wrap-around; the first eligible slot wins.
  - When there is a winner, the pointer updates at the edge to (winner+1) mod NUM_REQ; otherwise it holds.
- Log outputs:
  - log_wr_req_val = any winner; log_wr_req_data = {winner index, slot record}.
  - Outputs are combinational from registered state; the log accepts unconditionally.
  - Latency: req_val at cycle t -> log write at cycle t+1 when uncontested and not frozen.
  - When there is no winner, log_wr_req_data is 0.
- Throughput: one log write per cycle. Sustained input above 1 record/cycle aggregate produces drops.
- freeze: takes effect in the same cycle (no write while 1). Slots keep filling and dropping as above. On release, the pending slots drain in RR order from the current pointer.
- Drop counters: saturate at all-ones. drop_cnt_clr has priority over an increment in the same cycle (result 0).
- No internal sequencing beyond the slot, RR pointer and counter registers; reset mid-drain discards held records.

Optional Feature:
TRACKER_LOG_ARB_DROP_CNT_EN
- Defined: drop counters are implemented as described.
- Undefined: counter registers are not built; drop_cnt is tied to 0 and drop_cnt_clr is ignored. Slot and arbitration behaviour are unchanged.

Decomposition:
- tracker_pkg gains:
  - TRACKER_LOG_ARB_MAX_REQ = 16
  - a packed struct tracker_log_entry_struct {req_id, tracker_stats_struct stats}
  - TRACKER_LOG_ENTRY_W
- One sub-module: tracker_rr_arb. Inputs: req vector, pointer. Output: one-hot grant. It is purely combinational; the pointer register lives in tracker_log_arb.

Test Plan:
1. Single requester 2 pulses req_val at t=5, data 0xAA -> log_wr_req_val=1 at t=6 with data {2'd2, 0xAA}; slot_pending[2] clears at t=7.
2. All 4 requesters pulse at t=10 -> writes at t=11..14 from requesters 0,1,2,3 in that order; pointer ends at 0; no drops.
3. freeze=1 at t=0..20, requester 1 pulses at t=3 (0x11) and t=8 (0x22) -> no writes and drop_cnt[1]=1; after freeze falls at t=21, one write of 0x11 at t=21.
4. Requester 0 pulses every cycle for 10 cycles with the others idle -> 10 writes on consecutive cycles, zero drops (granted-and-refill case).
5. Requester 3 continuously blocked under freeze for 70000 pulses with DROP_CNT_W=16 -> drop_cnt[3] saturates at 0xFFFF; drop_cnt_clr together with a drop in the same cycle -> 0.
6. rst driven low asynchronously mid-cycle while slots are FULL -> log_wr_req_val, slot_pending and drop_cnt go to 0 immediately; after release, no stale write occurs.
